// File: rtl/pulse_stretch.sv
// Per-channel pulse stretcher: turns single-cycle strobes into level windows of i_len cycles.
// Define PULSE_STRETCH_RETRIGGER_EN to let triggers mid-window restart the window.
module pulse_stretch #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pulse_in,
  input  logic [CNT_W-1:0] i_len,
  output logic [WIDTH-1:0] o_level_out,
  output logic [WIDTH-1:0] o_busy,
  output logic [WIDTH-1:0] o_done
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic len_nonzero;
  assign len_nonzero = (i_len != '0);

  for (genvar k = 0; k < WIDTH; k++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             trig;
    logic             last_cycle;

    assign trig       = i_pulse_in[k] && len_nonzero;
    assign last_cycle = (cnt_q == CNT_ONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
      end
    end

    // A trigger in the final active cycle always merges into the next window.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_d = ACTIVE;
            cnt_d   = i_len;
          end
        end
        ACTIVE: begin
          if (trig && (last_cycle || RETRIGGER)) begin
            cnt_d = i_len;
          end else if (last_cycle) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign o_level_out[k] = (state_q == ACTIVE);
    assign o_busy[k]      = (state_q == ACTIVE);
    assign o_done[k]      = done_q;
  end

endmodule
